// File: rtl/exception_pkg.sv
// Shared definitions for the exception unit: FSM state encoding, cause codes,
// Status/Cause bit positions and the default handler entry address.
package exception_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_TAKEN   = 2'd1,
        ST_HANDLER = 2'd2
    } exc_state_e;

    localparam logic [3:0]  CAUSE_SW             = 4'd0;
    localparam int          IE_BIT               = 0;
    localparam int          DF_BIT               = 15;
    localparam logic [15:0] HANDLER_ADDR_DEFAULT = 16'h0010;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one interrupt line.
// Ports:
//   CLK     - system clock, rising edge
//   Reset   - asynchronous active-low reset
//   irq_i   - asynchronous, level-held interrupt request
//   pulse_o - one-cycle pulse on a synchronized rising edge
module irq_sync_edge (
    input  logic CLK,
    input  logic Reset,
    input  logic irq_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // High during the cycle the synchronized level first reads 1; the pending
    // latch in the parent captures it on the following edge (third edge overall).
    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/exception_unit.sv
// Exception state for the 16-bit multicycle datapath: EPC, Cause and Status
// registers, pending-interrupt latch, and the RUN/TAKEN/HANDLER state machine.
// Ports:
//   CLK, Reset                 - clock and asynchronous active-low reset
//   PC                         - address captured into EPC
//   EPCWrite, CauseWrite       - control-unit strobes for entering a handler
//   IntCause                   - 0 = software exception, 1 = external interrupt
//   ERet                       - return from handler
//   StatusWrite, StatusIn      - software load of the Status register
//   IRQ                        - asynchronous level interrupt requests
//   IntPending                 - interrupt request to the control unit
//   InHandler                  - high whenever the FSM is not in RUN
//   EPC, Cause, Status         - architectural exception registers
//   HandlerAddr                - constant handler entry address for the PC mux
module exception_unit
    import exception_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               NUM_IRQ      = 4,
    parameter logic [WIDTH-1:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   PC,
    input  logic               EPCWrite,
    input  logic               CauseWrite,
    input  logic               IntCause,
    input  logic               ERet,
    input  logic               StatusWrite,
    input  logic [WIDTH-1:0]   StatusIn,
    input  logic [NUM_IRQ-1:0] IRQ,
    output logic               IntPending,
    output logic               InHandler,
    output logic [WIDTH-1:0]   EPC,
    output logic [WIDTH-1:0]   Cause,
    output logic [WIDTH-1:0]   Status,
    output logic [WIDTH-1:0]   HandlerAddr
);

    // Only IE plus one mask bit per IRQ line are implemented in Status.
    localparam logic [WIDTH-1:0] STATUS_MASK = WIDTH'((1 << (NUM_IRQ + 1)) - 1);

    exc_state_e         state_q, state_d;
    logic [WIDTH-1:0]   epc_q, epc_d;
    logic [WIDTH-1:0]   cause_q, cause_d;
    logic [WIDTH-1:0]   status_q, status_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;

    logic [NUM_IRQ-1:0] edge_pulse;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] enabled;
    logic [NUM_IRQ-1:0] irq_sel;
    logic [3:0]         irq_code;
    logic               take;
    logic               dfault;
    logic               ret;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_irq
            irq_sync_edge u_sync (
                .CLK     (CLK),
                .Reset   (Reset),
                .irq_i   (IRQ[gi]),
                .pulse_o (edge_pulse[gi])
            );
        end
    endgenerate

    assign mask    = status_q[NUM_IRQ:1];
    assign enabled = pend_q & mask;

    // Lowest-index enabled pending line wins; scanning downward lets the
    // lowest index overwrite any higher one.
    always_comb begin
        irq_code = CAUSE_SW;
        irq_sel  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                irq_code   = 4'(i + 1);
                irq_sel    = '0;
                irq_sel[i] = 1'b1;
            end
        end
    end

    assign take   = CauseWrite && (state_q == ST_RUN);
    assign dfault = CauseWrite && (state_q != ST_RUN);
    // A CauseWrite in the same cycle is a double fault and suppresses the return.
    assign ret    = ERet && !CauseWrite && (state_q == ST_HANDLER);

    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        status_d = status_q;

        // A fresh edge on a line being serviced this cycle keeps it pending.
        pend_d = (pend_q & ~((take && IntCause) ? irq_sel : '0)) | edge_pulse;

        unique case (state_q)
            ST_RUN:     if (take) state_d = ST_TAKEN;
            ST_TAKEN:   state_d = ST_HANDLER;
            ST_HANDLER: if (ret) state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase

        if (EPCWrite && (state_q == ST_RUN)) begin
            epc_d = PC;
        end

        if (take) begin
            cause_d      = '0;
            cause_d[3:0] = IntCause ? irq_code : CAUSE_SW;
        end else if (dfault) begin
            cause_d[DF_BIT] = 1'b1;
        end

        // Entry/return override the IE bit written in the same cycle.
        if (StatusWrite) begin
            status_d = StatusIn & STATUS_MASK;
        end
        if (take) begin
            status_d[IE_BIT] = 1'b0;
        end else if (ret) begin
            status_d[IE_BIT] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_RUN;
            epc_q    <= '0;
            cause_q  <= '0;
            status_q <= '0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            status_q <= status_d;
            pend_q   <= pend_d;
        end
    end

    assign IntPending  = status_q[IE_BIT] & (|enabled) & (state_q == ST_RUN);
    assign InHandler   = (state_q != ST_RUN);
    assign EPC         = epc_q;
    assign Cause       = cause_q;
    assign Status      = status_q;
    assign HandlerAddr = HANDLER_ADDR;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: inputs change on the falling edge and
// outputs are compared on the falling edge after each rising edge.
module tb_exception_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [15:0] PC;
    logic        EPCWrite, CauseWrite, IntCause, ERet, StatusWrite;
    logic [15:0] StatusIn;
    logic [3:0]  IRQ;
    logic        IntPending, InHandler;
    logic [15:0] EPC, Cause, Status, HandlerAddr;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    exception_unit dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .PC          (PC),
        .EPCWrite    (EPCWrite),
        .CauseWrite  (CauseWrite),
        .IntCause    (IntCause),
        .ERet        (ERet),
        .StatusWrite (StatusWrite),
        .StatusIn    (StatusIn),
        .IRQ         (IRQ),
        .IntPending  (IntPending),
        .InHandler   (InHandler),
        .EPC         (EPC),
        .Cause       (Cause),
        .Status      (Status),
        .HandlerAddr (HandlerAddr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic clear_strobes();
        EPCWrite    = 1'b0;
        CauseWrite  = 1'b0;
        IntCause    = 1'b0;
        ERet        = 1'b0;
        StatusWrite = 1'b0;
    endtask

    task automatic write_status(input logic [15:0] v);
        StatusWrite = 1'b1;
        StatusIn    = v;
        step();
        clear_strobes();
    endtask

    task automatic enter(input logic ic, input logic [15:0] pc_v);
        EPCWrite   = 1'b1;
        CauseWrite = 1'b1;
        IntCause   = ic;
        PC         = pc_v;
        step();
        clear_strobes();
    endtask

    task automatic do_eret();
        ERet = 1'b1;
        step();
        clear_strobes();
    endtask

    initial begin
        Reset    = 1'b0;
        PC       = '0;
        StatusIn = '0;
        IRQ      = '0;
        clear_strobes();
        #3;
        check("rst_intpending", 32'(IntPending), 32'd0);
        check("rst_inhandler",  32'(InHandler),  32'd0);
        check("rst_epc",        32'(EPC),        32'h0);
        check("rst_cause",      32'(Cause),      32'h0);
        check("rst_status",     32'(Status),     32'h0);
        check("handler_addr",   32'(HandlerAddr), 32'h0010);
        step();
        Reset = 1'b1;
        step();

        // IRQ[0] edge with IE and mask0 set: pending exactly 3 edges later.
        write_status(16'h0003);
        check("t1_status", 32'(Status), 32'h0003);
        IRQ = 4'b0001;
        step();
        check("t1_pend_edge1", 32'(IntPending), 32'd0);
        step();
        check("t1_pend_edge2", 32'(IntPending), 32'd0);
        step();
        check("t1_pend_edge3", 32'(IntPending), 32'd1);
        enter(1'b1, 16'h1234);
        check("t1_epc",        32'(EPC),        32'h1234);
        check("t1_cause",      32'(Cause),      32'h0001);
        check("t1_status_ie0", 32'(Status),     32'h0002);
        check("t1_inhandler",  32'(InHandler),  32'd1);
        check("t1_intpending", 32'(IntPending), 32'd0);
        step(); // TAKEN -> HANDLER
        check("t1_still_in",   32'(InHandler),  32'd1);
        do_eret();
        check("t1_ret_inh",    32'(InHandler),  32'd0);
        check("t1_ret_status", 32'(Status),     32'h0003);
        check("t1_ret_nopend", 32'(IntPending), 32'd0);

        // Simultaneous edges on IRQ[1] and IRQ[2]: lowest index serviced first.
        IRQ = 4'b0000;
        step(); step(); step();
        write_status(16'h001F);
        IRQ = 4'b0110;
        step(); step(); step();
        check("t2_pending", 32'(IntPending), 32'd1);
        enter(1'b1, 16'h0200);
        check("t2_cause1", 32'(Cause), 32'h0002);
        step();
        do_eret();
        check("t2_ret_status", 32'(Status),     32'h001F);
        check("t2_ret_pend",   32'(IntPending), 32'd1);
        enter(1'b1, 16'h0202);
        check("t2_cause2", 32'(Cause), 32'h0003);
        step();
        do_eret();
        check("t2_drained", 32'(IntPending), 32'd0);

        // Software exception, then double fault while in HANDLER.
        enter(1'b0, 16'h00A0);
        check("t3_cause_sw", 32'(Cause), 32'h0000);
        check("t3_epc",      32'(EPC),   32'h00A0);
        step();
        enter(1'b0, 16'h0050);
        check("t3_df_cause", 32'(Cause),     32'h8000);
        check("t3_df_epc",   32'(EPC),       32'h00A0);
        check("t3_df_inh",   32'(InHandler), 32'd1);
        ERet       = 1'b1;
        CauseWrite = 1'b1;
        step();
        clear_strobes();
        check("t3_cw_eret_inh", 32'(InHandler), 32'd1);
        // ERet with StatusWrite: masks from StatusIn, IE forced to 1.
        ERet        = 1'b1;
        StatusWrite = 1'b1;
        StatusIn    = 16'h0000;
        step();
        clear_strobes();
        check("t3_eret_sw_inh",    32'(InHandler), 32'd0);
        check("t3_eret_sw_status", 32'(Status),    32'h0001);

        // IRQ[3] edge while masked: held pending, released by a Status write.
        IRQ = 4'b1110;
        step(); step(); step();
        check("t4_masked", 32'(IntPending), 32'd0);
        write_status(16'hFF11);
        check("t4_status_rsvd", 32'(Status),     32'h0011);
        check("t4_unmasked",    32'(IntPending), 32'd1);
        // CauseWrite with StatusWrite: masks from StatusIn, IE forced to 0.
        CauseWrite  = 1'b1;
        IntCause    = 1'b1;
        StatusWrite = 1'b1;
        StatusIn    = 16'h001F;
        step();
        clear_strobes();
        check("t4_cause",  32'(Cause),  32'h0004);
        check("t4_status", 32'(Status), 32'h001E);
        step(); // now in HANDLER

        // Reset mid-handler with pend[1] set.
        IRQ = 4'b1100;
        step(); step(); step();
        IRQ = 4'b1110;
        step(); step(); step();
        check("t5_in_handler", 32'(InHandler), 32'd1);
        IRQ = 4'b0000;
        #2;
        Reset = 1'b0;
        #1;
        check("t5_rst_intpend", 32'(IntPending),  32'd0);
        check("t5_rst_inh",     32'(InHandler),   32'd0);
        check("t5_rst_epc",     32'(EPC),         32'h0);
        check("t5_rst_cause",   32'(Cause),       32'h0);
        check("t5_rst_status",  32'(Status),      32'h0);
        check("t5_rst_haddr",   32'(HandlerAddr), 32'h0010);
        step();
        Reset = 1'b1;
        step();
        write_status(16'h0005);
        step(); step();
        check("t5_pend_lost", 32'(IntPending), 32'd0);
        IRQ = 4'b0010;
        step(); step();
        check("t5_edge2", 32'(IntPending), 32'd0);
        step();
        check("t5_edge3", 32'(IntPending), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
